lfsr_checker: RTL and testbench
===============================

# lfsr_checker

Serial sequence checker for the 8-bit XNOR LFSR generator (taps out[2], out[5]; new bit shifted into out[0]). Consumes the generator's output bit stream one bit per enabled clock, self-synchronises to it, asserts lock once the stream is verified, and then flags and counts bit errors. It sits directly downstream of the generator, either locally or across a link, as the receive-side built-in self-test monitor.

## Interface
- LOCK_COUNT, 16: consecutive correct predictions in SYNC required to declare lock (2..255).
- LOSS_THRESH, 4: consecutive errors in LOCKED that drop lock (1..15).
- ERR_W, 16: width of err_count.
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- en  input  1  din valid this cycle; the block does nothing when low.
- din  input  1  received sequence bit, i.e. the bit the generator shifts into out[0].
- clr_count  input  1  synchronous clear of err_count.
- locked  output  1  high while in LOCKED.
- err  output  1  one-cycle pulse: mismatch on a bit checked in LOCKED.
- lost_lock  output  1  one-cycle pulse on the LOCKED->HUNT transition.
- err_count  output  ERR_W  saturating count of err pulses.

## Operation
- Recurrence: s[n] = ~(s[n-3] ^ s[n-6]). A 6-bit shadow register holds the last six bits. Predicted bit = ~(shadow[2] ^ shadow[5]), with shadow[0] the newest bit.
- States: HUNT, SYNC, LOCKED. All actions occur only on cycles with en=1.
- HUNT: shift din into the shadow register and increment fill_cnt (3 bits). After the 6th bit:
  - If the shadow register including that bit is 6'b111111 (the XNOR lockup pattern / stuck-at-1 line), stay in HUNT and set fill_cnt to 0.
  - Otherwise go to SYNC with match_cnt = 0.
- SYNC: compare din with the predicted bit, then shift din into the shadow register.
  - Match: increment match_cnt. When it reaches LOCK_COUNT, go to LOCKED.
  - Mismatch: go to HUNT with fill_cnt = 0. No err pulse.
- LOCKED: shift the predicted bit into the shadow register, not din (flywheel, so errors do not propagate).
  - Mismatch: err=1 next cycle, err_count increments, miss_cnt increments.
  - Match: miss_cnt = 0.
  - miss_cnt reaching LOSS_THRESH: go to HUNT, lost_lock=1, fill_cnt = 0.
- err_count saturates at 2^ERR_W-1.
- clr_count and an error on the same cycle: the clear wins and err_count becomes 0.
- Reset value of every output is 0. Reset also puts the FSM in HUNT and clears the shadow register, fill_cnt, match_cnt and miss_cnt. Reset mid-stream aborts any lock immediately; the block re-acquires from HUNT.

## Timing
- Outputs are registered. locked rises on the clock edge that samples the LOCK_COUNT-th matching bit.
- err and lost_lock are high for exactly the cycle after the edge that samples the offending bit. lost_lock and the final err pulse coincide.
- Minimum acquisition: 6 + LOCK_COUNT enabled bits (22 at default). en-low cycles stretch this and do not count.
- err is never asserted when en was low on the sampling edge.

## Configuration
- LFSR_CHK_STATS_EN defined: the err_count register and the clr_count logic are built as described.
- LFSR_CHK_STATS_EN undefined: err_count is tied to 0 and clr_count is ignored. locked, err and lost_lock are unchanged.

## Test plan
- Clean stream, en=1 every cycle: feed the generator output from its reset state (first bits 1,1,1,0,0,0,0,0,0,1,...). locked rises after bit 22; err_count stays 0 over 1000 bits.
- Single bit flip at bit 100 after lock: err pulses once, err_count=1, locked stays high, and later bits produce no further errors (flywheel).
- Four consecutive flipped bits after lock: four err pulses, and lost_lock coincides with the 4th. locked falls, the block re-hunts, and relocks 22 bits later.
- din held at 1: the block never leaves HUNT. locked, err and err_count all remain 0.
- en toggled 50% with a clean stream: lock is reached after 22 enabled bits with no errors. Then assert reset low mid-stream: all outputs are 0 asynchronously and the block relocks.
- Force err_count to saturate (ERR_W=4, inject 20 errors while keeping lock): err_count=15. Then clr_count together with an error: err_count=0.

Source files
------------

// File: rtl/lfsr_checker.sv
// Receive-side self-synchronising checker for the 8-bit XNOR LFSR stream (taps out[2], out[5]).
// Define LFSR_CHK_STATS_EN to build the saturating err_count register and its clr_count clear.
module lfsr_checker #(
    parameter int LOCK_COUNT  = 16,
    parameter int LOSS_THRESH = 4,
    parameter int ERR_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             din,
    input  logic             clr_count,
    output logic             locked,
    output logic             err,
    output logic             lost_lock,
    output logic [ERR_W-1:0] err_count
);

    typedef enum logic [1:0] {
        HUNT,
        SYNC,
        LOCKED
    } state_t;

    state_t     state;
    logic [5:0] shadow;
    logic [2:0] fill_cnt;
    logic [7:0] match_cnt;
    logic [3:0] miss_cnt;

    logic       predicted;
    logic       mismatch;
    logic       bit_err;
    logic [5:0] shadow_in;

    // shadow[0] is the newest bit, so shadow[2] = s[n-3] and shadow[5] = s[n-6].
    assign predicted = ~(shadow[2] ^ shadow[5]);
    assign mismatch  = din ^ predicted;
    assign bit_err   = en && (state == LOCKED) && mismatch;
    assign shadow_in = {shadow[4:0], din};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= HUNT;
            shadow    <= '0;
            fill_cnt  <= '0;
            match_cnt <= '0;
            miss_cnt  <= '0;
            locked    <= 1'b0;
            err       <= 1'b0;
            lost_lock <= 1'b0;
        end else begin
            // NOTE: pulse outputs default low on every edge (even with en low) and are
            // overridden below, which keeps them one cycle wide without extra clear logic.
            err       <= 1'b0;
            lost_lock <= 1'b0;
            if (en) begin
                case (state)
                    HUNT: begin
                        shadow <= shadow_in;
                        if (fill_cnt == 3'd5) begin
                            fill_cnt <= '0;
                            if (shadow_in != 6'b111111) begin
                                state     <= SYNC;
                                match_cnt <= '0;
                            end
                        end else begin
                            fill_cnt <= fill_cnt + 3'd1;
                        end
                    end
                    SYNC: begin
                        shadow <= shadow_in;
                        if (!mismatch) begin
                            match_cnt <= match_cnt + 8'd1;
                            if (match_cnt == 8'(LOCK_COUNT - 1)) begin
                                state    <= LOCKED;
                                locked   <= 1'b1;
                                miss_cnt <= '0;
                            end
                        end else begin
                            state    <= HUNT;
                            fill_cnt <= '0;
                        end
                    end
                    LOCKED: begin
                        // Flywheel: the prediction, not the received bit, feeds the history.
                        shadow <= {shadow[4:0], predicted};
                        if (mismatch) begin
                            err <= 1'b1;
                            if (miss_cnt == 4'(LOSS_THRESH - 1)) begin
                                state     <= HUNT;
                                locked    <= 1'b0;
                                lost_lock <= 1'b1;
                                fill_cnt  <= '0;
                                miss_cnt  <= '0;
                            end else begin
                                miss_cnt <= miss_cnt + 4'd1;
                            end
                        end else begin
                            miss_cnt <= '0;
                        end
                    end
                    default: begin
                        state    <= HUNT;
                        fill_cnt <= '0;
                    end
                endcase
            end
        end
    end

`ifdef LFSR_CHK_STATS_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_count <= '0;
        end else if (clr_count) begin
            err_count <= '0;
        end else if (bit_err && (err_count != {ERR_W{1'b1}})) begin
            err_count <= err_count + ERR_W'(1);
        end
    end
`else
    logic unused_stats;
    assign unused_stats = clr_count ^ bit_err;
    assign err_count    = '0;
`endif

endmodule

// File: tb/tb_lfsr_checker.sv
// Directed bench for lfsr_checker: a reference generator drives the stream, expectations are hand-derived.
`timescale 1ns/1ps
module tb_lfsr_checker;

    localparam int LOCK_COUNT  = 16;
    localparam int LOSS_THRESH = 4;
    localparam int ERR_W       = 4;
`ifdef LFSR_CHK_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             reset;
    logic             en;
    logic             din;
    logic             clr_count;
    logic             locked;
    logic             err;
    logic             lost_lock;
    logic [ERR_W-1:0] err_count;

    int         pass_cnt  = 0;
    int         total_cnt = 0;
    logic [7:0] gen;

    lfsr_checker #(
        .LOCK_COUNT (LOCK_COUNT),
        .LOSS_THRESH(LOSS_THRESH),
        .ERR_W      (ERR_W)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .en       (en),
        .din      (din),
        .clr_count(clr_count),
        .locked   (locked),
        .err      (err),
        .lost_lock(lost_lock),
        .err_count(err_count)
    );

    always #5 clk = ~clk;

    // Expected err_count: the counter only exists when statistics are built.
    function automatic logic [ERR_W-1:0] exp_cnt(input int n);
        return STATS ? ERR_W'(n) : '0;
    endfunction

    // Reference 8-bit XNOR generator, taps out[2] and out[5], new bit into out[0].
    task automatic gen_bit(output logic b);
        b   = ~(gen[2] ^ gen[5]);
        gen = {gen[6:0], b};
    endtask

    // Drive one cycle of inputs and return 1ns after the sampling edge.
    task automatic step(input logic e, input logic d);
        en  = e;
        din = d;
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        reset     = 1'b0;
        en        = 1'b0;
        din       = 1'b0;
        clr_count = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    task automatic acquire();
        logic b;
        for (int i = 0; i < 6 + LOCK_COUNT; i++) begin
            gen_bit(b);
            step(1'b1, b);
        end
        total_cnt++;
        if (locked !== 1'b1) $display("FAIL acquire_locked: locked=%b expected 1", locked);
        else pass_cnt++;
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        en        = 1'b0;
        din       = 1'b0;
        clr_count = 1'b0;
        #2 reset  = 1'b0;
        #1;
        total_cnt++;
        if (locked !== 1'b0) $display("FAIL reset_locked: locked=%b expected 0", locked);
        else pass_cnt++;
        total_cnt++;
        if (err !== 1'b0) $display("FAIL reset_err: err=%b expected 0", err);
        else pass_cnt++;
        total_cnt++;
        if (lost_lock !== 1'b0) $display("FAIL reset_lost_lock: lost_lock=%b expected 0", lost_lock);
        else pass_cnt++;
        total_cnt++;
        if (err_count !== '0) $display("FAIL reset_err_count: err_count=%0d expected 0", err_count);
        else pass_cnt++;
        step(1'b1, 1'b1);
        total_cnt++;
        if (locked !== 1'b0) $display("FAIL reset_held: locked=%b expected 0", locked);
        else pass_cnt++;
        reset = 1'b1;
    endtask

    task automatic test_clean_lock();
        logic b;
        int   errs  = 0;
        int   losts = 0;
        apply_reset();
        gen = '0;
        for (int i = 1; i <= 1000; i++) begin
            gen_bit(b);
            step(1'b1, b);
            if (err) errs++;
            if (lost_lock) losts++;
            if (i == 21) begin
                total_cnt++;
                if (locked !== 1'b0) $display("FAIL clean_locked_bit21: locked=%b expected 0", locked);
                else pass_cnt++;
            end
            if (i == 22) begin
                total_cnt++;
                if (locked !== 1'b1) $display("FAIL clean_locked_bit22: locked=%b expected 1", locked);
                else pass_cnt++;
            end
        end
        total_cnt++;
        if (errs != 0) $display("FAIL clean_err_pulses: got %0d expected 0", errs);
        else pass_cnt++;
        total_cnt++;
        if (losts != 0) $display("FAIL clean_lost_pulses: got %0d expected 0", losts);
        else pass_cnt++;
        total_cnt++;
        if (locked !== 1'b1) $display("FAIL clean_locked_end: locked=%b expected 1", locked);
        else pass_cnt++;
        total_cnt++;
        if (err_count !== '0) $display("FAIL clean_err_count: err_count=%0d expected 0", err_count);
        else pass_cnt++;
    endtask

    task automatic test_single_flip();
        logic b;
        int   errs  = 0;
        int   drops = 0;
        apply_reset();
        gen = '0;
        acquire();
        for (int i = 1; i <= 300; i++) begin
            gen_bit(b);
            step(1'b1, (i == 100) ? ~b : b);
            if (err) errs++;
            if (!locked) drops++;
            if (i == 100) begin
                total_cnt++;
                if (err !== 1'b1) $display("FAIL flip_err_pulse: err=%b expected 1", err);
                else pass_cnt++;
            end
            if (i == 101) begin
                total_cnt++;
                if (err !== 1'b0) $display("FAIL flip_err_one_cycle: err=%b expected 0", err);
                else pass_cnt++;
            end
        end
        total_cnt++;
        if (errs != 1) $display("FAIL flip_err_total: got %0d expected 1", errs);
        else pass_cnt++;
        total_cnt++;
        if (drops != 0) $display("FAIL flip_lock_kept: unlocked cycles %0d expected 0", drops);
        else pass_cnt++;
        total_cnt++;
        if (err_count !== exp_cnt(1)) $display("FAIL flip_err_count: err_count=%0d expected %0d", err_count, exp_cnt(1));
        else pass_cnt++;
    endtask

    task automatic test_loss_relock();
        logic b;
        apply_reset();
        gen = '0;
        acquire();
        for (int i = 0; i < 10; i++) begin
            gen_bit(b);
            step(1'b1, b);
        end
        for (int k = 1; k <= LOSS_THRESH; k++) begin
            gen_bit(b);
            step(1'b1, ~b);
            total_cnt++;
            if (err !== 1'b1) $display("FAIL loss_err_%0d: err=%b expected 1", k, err);
            else pass_cnt++;
            total_cnt++;
            if (lost_lock !== (k == LOSS_THRESH)) $display("FAIL loss_lost_lock_%0d: lost_lock=%b expected %b", k, lost_lock, k == LOSS_THRESH);
            else pass_cnt++;
            total_cnt++;
            if (locked !== (k != LOSS_THRESH)) $display("FAIL loss_locked_%0d: locked=%b expected %b", k, locked, k != LOSS_THRESH);
            else pass_cnt++;
        end
        for (int i = 1; i <= 22; i++) begin
            gen_bit(b);
            step(1'b1, b);
            if (i == 1) begin
                total_cnt++;
                if ({err, lost_lock} !== 2'b00) $display("FAIL loss_pulses_clear: err,lost_lock=%b expected 00", {err, lost_lock});
                else pass_cnt++;
            end
            if (i == 21) begin
                total_cnt++;
                if (locked !== 1'b0) $display("FAIL relock_bit21: locked=%b expected 0", locked);
                else pass_cnt++;
            end
            if (i == 22) begin
                total_cnt++;
                if (locked !== 1'b1) $display("FAIL relock_bit22: locked=%b expected 1", locked);
                else pass_cnt++;
            end
        end
        total_cnt++;
        if (err_count !== exp_cnt(4)) $display("FAIL loss_err_count: err_count=%0d expected %0d", err_count, exp_cnt(4));
        else pass_cnt++;
    endtask

    task automatic test_stuck_ones();
        int highs = 0;
        apply_reset();
        for (int i = 0; i < 200; i++) begin
            step(1'b1, 1'b1);
            if (locked || err || lost_lock) highs++;
        end
        total_cnt++;
        if (highs != 0) $display("FAIL stuck_outputs: active cycles %0d expected 0", highs);
        else pass_cnt++;
        total_cnt++;
        if (err_count !== '0) $display("FAIL stuck_err_count: err_count=%0d expected 0", err_count);
        else pass_cnt++;
    endtask

    task automatic test_en_toggle();
        logic b;
        int   nen  = 0;
        int   errs = 0;
        apply_reset();
        gen = '0;
        for (int c = 0; c < 80; c++) begin
            if (c % 2 == 0) begin
                gen_bit(b);
                nen++;
                step(1'b1, b);
                if (nen == 21) begin
                    total_cnt++;
                    if (locked !== 1'b0) $display("FAIL en_toggle_bit21: locked=%b expected 0", locked);
                    else pass_cnt++;
                end
                if (nen == 22) begin
                    total_cnt++;
                    if (locked !== 1'b1) $display("FAIL en_toggle_bit22: locked=%b expected 1", locked);
                    else pass_cnt++;
                end
            end else begin
                step(1'b0, 1'($urandom_range(0, 1)));
            end
            if (err) errs++;
        end
        total_cnt++;
        if (errs != 0) $display("FAIL en_toggle_errs: got %0d expected 0", errs);
        else pass_cnt++;
    endtask

    task automatic test_async_reset();
        logic b;
        gen_bit(b);
        step(1'b1, ~b);
        total_cnt++;
        if (err !== 1'b1) $display("FAIL async_pre_err: err=%b expected 1", err);
        else pass_cnt++;
        #3 reset = 1'b0;
        #1;
        total_cnt++;
        if ({locked, err, lost_lock} !== 3'b000) $display("FAIL async_outputs: locked,err,lost_lock=%b expected 000", {locked, err, lost_lock});
        else pass_cnt++;
        total_cnt++;
        if (err_count !== '0) $display("FAIL async_err_count: err_count=%0d expected 0", err_count);
        else pass_cnt++;
        @(posedge clk);
        #1 reset = 1'b1;
        for (int i = 1; i <= 22; i++) begin
            gen_bit(b);
            step(1'b1, b);
            if (i == 21) begin
                total_cnt++;
                if (locked !== 1'b0) $display("FAIL async_relock_bit21: locked=%b expected 0", locked);
                else pass_cnt++;
            end
            if (i == 22) begin
                total_cnt++;
                if (locked !== 1'b1) $display("FAIL async_relock_bit22: locked=%b expected 1", locked);
                else pass_cnt++;
            end
        end
    endtask

    task automatic test_saturation();
        logic b;
        int   losts = 0;
        apply_reset();
        gen = '0;
        acquire();
        for (int k = 0; k < 20; k++) begin
            gen_bit(b);
            step(1'b1, ~b);
            if (lost_lock) losts++;
            gen_bit(b);
            step(1'b1, b);
        end
        total_cnt++;
        if (locked !== 1'b1 || losts != 0) $display("FAIL sat_lock_kept: locked=%b lost=%0d expected 1/0", locked, losts);
        else pass_cnt++;
        total_cnt++;
        if (err_count !== exp_cnt(15)) $display("FAIL sat_err_count: err_count=%0d expected %0d", err_count, exp_cnt(15));
        else pass_cnt++;
        clr_count = 1'b1;
        gen_bit(b);
        step(1'b1, ~b);
        clr_count = 1'b0;
        total_cnt++;
        if (err !== 1'b1) $display("FAIL clr_err_pulse: err=%b expected 1", err);
        else pass_cnt++;
        total_cnt++;
        if (err_count !== '0) $display("FAIL clr_wins: err_count=%0d expected 0", err_count);
        else pass_cnt++;
        gen_bit(b);
        step(1'b1, b);
        gen_bit(b);
        step(1'b1, ~b);
        total_cnt++;
        if (err_count !== exp_cnt(1)) $display("FAIL clr_then_count: err_count=%0d expected %0d", err_count, exp_cnt(1));
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_clean_lock();
        test_single_flip();
        test_loss_relock();
        test_stuck_ones();
        test_en_toggle();
        test_async_reset();
        test_saturation();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
